// File: rtl/id_ex_stage_if.sv
// Decode-side bundle feeding the ID/EX stage register, plus the load-use
// stall that decode must obey.
interface id_ex_stage_if #(
  parameter int WIDTH = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [WIDTH-1:0] id_rs1_data;
  logic [WIDTH-1:0] id_rs2_data;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_imm;
  logic             id_use_pc_a;
  logic             id_use_imm_b;
  logic [10:0]      id_alu_sel;
  logic [4:0]       id_rd_addr;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_stall;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_pc, id_imm, id_use_pc_a, id_use_imm_b, id_alu_sel,
           id_rd_addr, id_reg_write, id_mem_read,
    input  id_stall
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_pc, id_imm, id_use_pc_a, id_use_imm_b, id_alu_sel,
           id_rd_addr, id_reg_write, id_mem_read,
    output id_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use hazard
// detection, bubble insertion, flush and downstream stall handling.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     id,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic [WIDTH-1:0] wb_result,
  input  logic             stall_in,
  input  logic             ex_flush,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [10:0]      alu_sel,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic [4:0]       ex_rd_addr,
  output logic [WIDTH-1:0] ex_store_data
);

  logic [4:0]       rs1_addr_q, rs2_addr_q;
  logic [WIDTH-1:0] rs1_data_q, rs2_data_q, pc_q, imm_q;
  logic             use_pc_a_q, use_imm_b_q;
  logic [WIDTH-1:0] rs1_fwd, rs2_fwd;

  // MEM beats WB; x0 never matches because rd==0 is excluded.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs1_addr_q)
      rs1_fwd = mem_result;
    else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs1_addr_q)
      rs1_fwd = wb_result;

    rs2_fwd = rs2_data_q;
    if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs2_addr_q)
      rs2_fwd = mem_result;
    else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs2_addr_q)
      rs2_fwd = wb_result;
  end

  assign operand_a     = use_pc_a_q  ? pc_q  : rs1_fwd;
  assign operand_b     = use_imm_b_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;

  assign id.id_stall = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id.id_valid &&
                       ((ex_rd_addr == id.id_rs1_addr) || (ex_rd_addr == id.id_rs2_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      alu_sel      <= '0;
      ex_rd_addr   <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      use_pc_a_q   <= 1'b0;
      use_imm_b_q  <= 1'b0;
    end else if (ex_flush || (!stall_in && id.id_stall)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      alu_sel      <= '0;
    end else if (stall_in) begin
      // Control holds, but operands absorb forwards so a retiring WB value survives the stall.
      rs1_data_q <= rs1_fwd;
      rs2_data_q <= rs2_fwd;
    end else begin
      ex_valid     <= id.id_valid;
      ex_reg_write <= id.id_valid && id.id_reg_write;
      ex_mem_read  <= id.id_valid && id.id_mem_read;
      alu_sel      <= id.id_valid ? id.id_alu_sel : '0;
      ex_rd_addr   <= id.id_rd_addr;
      rs1_addr_q   <= id.id_rs1_addr;
      rs2_addr_q   <= id.id_rs2_addr;
      rs1_data_q   <= id.id_rs1_data;
      rs2_data_q   <= id.id_rs2_data;
      pc_q         <= id.id_pc;
      imm_q        <= id.id_imm;
      use_pc_a_q   <= id.id_use_pc_a;
      use_imm_b_q  <= id.id_use_imm_b;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/forward/reset scenarios
// followed by randomised traffic against a behavioural stage model.
module tb_id_ex_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0]   mem_rd_addr, wb_rd_addr, ex_rd_addr;
  logic         mem_reg_write, wb_reg_write, stall_in, ex_flush;
  logic [W-1:0] mem_result, wb_result, operand_a, operand_b, ex_store_data;
  logic [10:0]  alu_sel;
  logic         ex_valid, ex_reg_write, ex_mem_read;

  id_ex_stage_if #(.WIDTH(W)) ifc ();

  id_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .id(ifc),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .stall_in(stall_in), .ex_flush(ex_flush),
    .operand_a(operand_a), .operand_b(operand_b), .alu_sel(alu_sel),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of the stage register contents
  logic         m_v, m_rw, m_mr, m_upc, m_uimm;
  logic [10:0]  m_sel;
  logic [4:0]   m_rd, m_rs1a, m_rs2a;
  logic [W-1:0] m_rs1d, m_rs2d, m_pc, m_imm;

  typedef struct packed {
    logic [W-1:0] a, b, sd;
    logic [10:0]  sel;
    logic         v, rw, mr;
    logic [4:0]   rd;
  } exp_t;
  exp_t sb[$];

  task automatic m_reset();
    m_v = 0; m_rw = 0; m_mr = 0; m_upc = 0; m_uimm = 0; m_sel = '0;
    m_rd = '0; m_rs1a = '0; m_rs2a = '0; m_rs1d = '0; m_rs2d = '0; m_pc = '0; m_imm = '0;
  endtask

  function automatic logic [W-1:0] mfwd(input logic [4:0] a, input logic [W-1:0] s);
    if (a != 0 && mem_reg_write && mem_rd_addr == a) return mem_result;
    if (a != 0 && wb_reg_write && wb_rd_addr == a) return wb_result;
    return s;
  endfunction

  // Called after inputs settle, before the rising edge; returns at the next falling edge.
  task automatic step(input string tag);
    logic hz;
    exp_t e, g;
    hz = m_v && m_mr && m_rd != 0 && ifc.id_valid &&
         (m_rd == ifc.id_rs1_addr || m_rd == ifc.id_rs2_addr);
    #1 check({tag, ".id_stall"}, ifc.id_stall, hz);
    if (ex_flush || (!stall_in && hz)) begin
      m_v = 0; m_rw = 0; m_mr = 0; m_sel = '0;
    end else if (stall_in) begin
      m_rs1d = mfwd(m_rs1a, m_rs1d);
      m_rs2d = mfwd(m_rs2a, m_rs2d);
    end else begin
      m_v = ifc.id_valid;
      m_rw = ifc.id_valid & ifc.id_reg_write;
      m_mr = ifc.id_valid & ifc.id_mem_read;
      m_sel = ifc.id_valid ? ifc.id_alu_sel : 11'h0;
      m_rd = ifc.id_rd_addr; m_rs1a = ifc.id_rs1_addr; m_rs2a = ifc.id_rs2_addr;
      m_rs1d = ifc.id_rs1_data; m_rs2d = ifc.id_rs2_data;
      m_pc = ifc.id_pc; m_imm = ifc.id_imm; m_upc = ifc.id_use_pc_a; m_uimm = ifc.id_use_imm_b;
    end
    e.a = m_upc ? m_pc : mfwd(m_rs1a, m_rs1d);
    e.b = m_uimm ? m_imm : mfwd(m_rs2a, m_rs2d);
    e.sd = mfwd(m_rs2a, m_rs2d);
    e.sel = m_sel; e.v = m_v; e.rw = m_rw; e.mr = m_mr; e.rd = m_rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      g = '{operand_a, operand_b, ex_store_data, alu_sel, ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr};
      check({tag, ".operand_a"}, g.a, e.a);
      check({tag, ".operand_b"}, g.b, e.b);
      check({tag, ".store_data"}, g.sd, e.sd);
      check({tag, ".alu_sel"}, g.sel, e.sel);
      check({tag, ".ctrl"}, {g.v, g.rw, g.mr, g.rd}, {e.v, e.rw, e.mr, e.rd});
    end
    @(negedge clk);
  endtask

  task automatic clr_id();
    ifc.id_valid = 0; ifc.id_rs1_addr = 0; ifc.id_rs2_addr = 0;
    ifc.id_rs1_data = 0; ifc.id_rs2_data = 0; ifc.id_pc = 0; ifc.id_imm = 0;
    ifc.id_use_pc_a = 0; ifc.id_use_imm_b = 0; ifc.id_alu_sel = 0;
    ifc.id_rd_addr = 0; ifc.id_reg_write = 0; ifc.id_mem_read = 0;
  endtask

  task automatic clr_fwd();
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input logic [4:0] rd, input logic [10:0] sel,
                        input logic mr);
    ifc.id_valid = 1; ifc.id_rs1_addr = rs1; ifc.id_rs2_addr = rs2;
    ifc.id_rs1_data = d1; ifc.id_rs2_data = d2; ifc.id_rd_addr = rd;
    ifc.id_alu_sel = sel; ifc.id_reg_write = 1; ifc.id_mem_read = mr;
    ifc.id_use_pc_a = 0; ifc.id_use_imm_b = 0; ifc.id_pc = 32'h100; ifc.id_imm = 32'h4;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; stall_in = 0; ex_flush = 0;
    clr_id(); clr_fwd(); m_reset();
    @(negedge clk); @(negedge clk);
    check("rst.ex_valid", ex_valid, 0);
    check("rst.alu_sel", alu_sel, 0);
    check("rst.operand_a", operand_a, 0);
    check("rst.id_stall", ifc.id_stall, 0);
    rst_n = 1;

    // ADD x3,x1,x2
    set_id(1, 2, 5, 7, 3, 11'h001, 0);
    step("add");
    check("add.a", operand_a, 5);
    check("add.b", operand_b, 7);
    check("add.valid", {ex_valid, alu_sel}, {1'b1, 11'h001});

    // Forward priority on rs1=4
    set_id(4, 0, 32'h10, 0, 6, 11'h001, 0);
    step("fwd_cap");
    clr_id();
    mem_rd_addr = 4; mem_reg_write = 1; mem_result = 32'hAA;
    wb_rd_addr = 4; wb_reg_write = 1; wb_result = 32'hBB;
    #1 check("fwd.mem", operand_a, 32'hAA);
    mem_reg_write = 0;
    #1 check("fwd.wb", operand_a, 32'hBB);
    step("fwd_wb");
    clr_fwd();

    // Load-use: LW x5 then instruction reading rs2=x5
    set_id(1, 0, 0, 0, 5, 11'h001, 1);
    step("lw");
    set_id(2, 5, 32'h22, 32'h55, 7, 11'h002, 0);
    #1 check("lu.id_stall", ifc.id_stall, 1);
    step("lu_bubble");
    check("lu.bubble", {ex_valid, alu_sel}, {1'b0, 11'h000});
    step("lu_capture");
    check("lu.capture", {ex_valid, ex_rd_addr}, {1'b1, 5'd7});

    // Downstream stall while WB retires x1
    set_id(1, 0, 32'h11, 0, 6, 11'h080, 0);
    step("st_cap");
    set_id(2, 3, 1, 2, 8, 11'h001, 0);
    stall_in = 1; wb_rd_addr = 1; wb_reg_write = 1; wb_result = 32'h1234;
    for (int unsigned i = 0; i < 3; i++) begin
      step("stall");
      clr_fwd();
      #1 check("stall.hold_a", operand_a, 32'h1234);
    end
    stall_in = 0; clr_id();
    #1 check("stall.release_a", operand_a, 32'h1234);
    step("st_release");

    // x0 is never forwarded
    set_id(0, 0, 0, 0, 9, 11'h001, 0);
    step("x0_cap");
    mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'hFFFF;
    #1 check("x0.a", operand_a, 0);
    clr_fwd();

    // Flush overrides stall
    set_id(1, 2, 3, 4, 10, 11'h040, 0);
    step("fl_cap");
    ex_flush = 1; stall_in = 1;
    step("flush");
    check("flush.bubble", {ex_valid, alu_sel}, {1'b0, 11'h000});
    ex_flush = 0; stall_in = 0;

    // Asynchronous reset mid-stall
    set_id(1, 2, 32'h77, 32'h88, 11, 11'h200, 1);
    step("rs_cap");
    stall_in = 1;
    #2 rst_n = 0;
    #1 check("arst.ctrl", {ex_valid, ex_reg_write, ex_mem_read, alu_sel, ex_rd_addr}, 0);
    check("arst.data", {operand_a, operand_b}, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1; stall_in = 0;
    set_id(3, 4, 32'h33, 32'h44, 12, 11'h400, 0);
    step("post_rst");
    check("post_rst.valid", {ex_valid, ex_rd_addr}, {1'b1, 5'd12});

    // Non-one-hot select passes through untouched
    set_id(1, 2, 1, 2, 13, 11'h0A5, 0);
    ifc.id_use_pc_a = 1; ifc.id_use_imm_b = 1;
    step("sel_raw");
    check("sel_raw.sel", alu_sel, 11'h0A5);
    check("sel_raw.ab", {operand_a, operand_b}, {32'h100, 32'h4});

    // Randomised traffic against the model
    for (int unsigned i = 0; i < 300; i++) begin
      ifc.id_valid = ($urandom_range(0, 3) != 0);
      ifc.id_rs1_addr = 5'($urandom_range(0, 3));
      ifc.id_rs2_addr = 5'($urandom_range(0, 3));
      ifc.id_rd_addr = 5'($urandom_range(0, 3));
      ifc.id_rs1_data = $urandom; ifc.id_rs2_data = $urandom;
      ifc.id_pc = $urandom; ifc.id_imm = $urandom;
      ifc.id_use_pc_a = 1'($urandom_range(0, 1));
      ifc.id_use_imm_b = 1'($urandom_range(0, 1));
      ifc.id_alu_sel = 11'(1 << $urandom_range(0, 10));
      ifc.id_reg_write = 1'($urandom_range(0, 1));
      ifc.id_mem_read = ($urandom_range(0, 2) == 0);
      mem_rd_addr = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom_range(0, 1));
      mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom_range(0, 1));
      wb_result = $urandom;
      stall_in = ($urandom_range(0, 3) == 0);
      ex_flush = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands, immediates and forwarded results.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 id_valid  in  1  decode holds a valid instruction.
REQ-005 id_rs1_addr, id_rs2_addr  in  5 each  source register indices.
REQ-006 id_rs1_data, id_rs2_data  in  WIDTH each  register-file read data.
REQ-007 id_pc, id_imm  in  WIDTH each  instruction PC, sign-extended immediate.
REQ-008 id_use_pc_a, id_use_imm_b  in  1 each  select PC for operand A, immediate for operand B.
REQ-009 id_alu_sel  in  11  one-hot op; bit0..10 = add, sub, mul, mulh, mulhsu, mulhu, and, or, xor, slt, sltu.
REQ-010 id_rd_addr  in  5; id_reg_write, id_mem_read  in  1 each  destination and control.
REQ-011 mem_rd_addr  in  5; mem_reg_write  in  1; mem_result  in  WIDTH  MEM-stage forward source.
REQ-012 wb_rd_addr  in  5; wb_reg_write  in  1; wb_result  in  WIDTH  WB-stage forward source.
REQ-013 stall_in  in  1  downstream stall; ex_flush  in  1  kill EX-stage instruction.
REQ-014 operand_a, operand_b  out  WIDTH each  ALU operands.
REQ-015 alu_sel  out  11  one-hot ALU select, same bit map as id_alu_sel; all-zero for bubble.
REQ-016 ex_valid, ex_reg_write, ex_mem_read  out  1 each; ex_rd_addr  out  5; ex_store_data  out  WIDTH (forwarded rs2).
REQ-017 id_stall  out  1  combinational; decode must hold its instruction.

Function
REQ-018 Stage register SHALL capture all id_* fields on a clock edge when stall_in=0, id_stall=0, ex_flush=0.
REQ-019 Captured instruction SHALL appear on outputs one cycle after capture (latency 1).
REQ-020 id_stall SHALL be 1 when ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs1_addr or ex_rd_addr==id_rs2_addr), else 0.
REQ-021 id_stall=1 with stall_in=0 SHALL load a bubble: ex_valid, ex_reg_write, ex_mem_read = 0, alu_sel = 0.
REQ-022 id_valid=0 at capture SHALL load a bubble identically.
REQ-023 ex_flush=1 SHALL load a bubble on the next edge, overriding stall_in and id_stall.
REQ-024 stall_in=1 (no flush) SHALL hold all control fields; rs1/rs2 data registers SHALL reload with currently forwarded values so a retiring WB result is not lost.
REQ-025 Forwarded rs1 SHALL be mem_result if mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==rs1; else wb_result on same test with wb; else stored rs1 data; rs2 likewise.
REQ-026 MEM forward SHALL take priority over WB when both match.
REQ-027 Register x0 SHALL never be forwarded; rs index 0 always yields stored data.
REQ-028 operand_a SHALL be stored PC if use_pc_a else forwarded rs1; operand_b stored imm if use_imm_b else forwarded rs2.
REQ-029 ex_store_data SHALL equal forwarded rs2 regardless of use_imm_b.
REQ-030 Forwarding and operand selection SHALL be combinational from stage registers and mem/wb inputs; no added latency.
REQ-031 Non-one-hot id_alu_sel SHALL be captured unchanged; no correction performed.

Reset
REQ-032 rst_n=0 SHALL immediately clear ex_valid, ex_reg_write, ex_mem_read, alu_sel, ex_rd_addr and all data registers to 0, independent of clk.
REQ-033 Reset asserted mid-stall SHALL discard held instruction; first edge after release SHALL capture per REQ-018.
REQ-034 After reset, id_stall SHALL be 0 (ex_valid=0).

Verification
REQ-035 ADD x3,x1,x2 with rs1_data=5, rs2_data=7, no hazards -> next cycle operand_a=5, operand_b=7, alu_sel=0x001, ex_valid=1.
REQ-036 rs1=4, mem_rd_addr=4, mem_reg_write=1, mem_result=0xAA, wb_rd_addr=4, wb_result=0xBB -> operand_a=0xAA; drop MEM match -> 0xBB.
REQ-037 EX holds LW x5, ID instr reads rs2=5 -> id_stall=1; next cycle ex_valid=0, alu_sel=0; following cycle instruction captured.
REQ-038 stall_in=1 for 3 cycles while WB forwards 0x1234 to rs1 in first cycle only -> operand_a stays 0x1234 through release.
REQ-039 rs1=0 with mem_rd_addr=0, mem_reg_write=1, mem_result=0xFFFF -> operand_a=stored data (0).
REQ-040 ex_flush=1 together with stall_in=1 -> next cycle ex_valid=0, alu_sel=0; rst_n low mid-cycle -> outputs 0 without clock edge.
